emergency_preempt_arbiter: RTL
==============================

# emergency_preempt_arbiter

Arbitrates emergency-vehicle preemption requests from several roadside detectors and drives the single `emergency_left` / `emergency_right` pair of `traffic_signals`. It grants one requester at a time in round-robin order and waits for the granted approach to show GREEN. It then holds the preemption for a bounded time and enforces a cooldown before the next grant. One clock tick is one second, the same 1 Hz clock as `traffic_signals`.

## Interface
- `NUM_REQ`, 4: number of detector requesters (2..8).
- `HOLD_MIN`, 10: minimum ticks the preemption is held once GREEN is reached.
- `HOLD_MAX`, 30: maximum ticks in HOLD before forced release.
- `GRANT_TIMEOUT`, 15: maximum ticks to wait for target GREEN.
- `COOLDOWN`, 5: ticks with both emergency lines low between grants.
- `CNT_W`, 6: tick counter width; must hold max(HOLD_MAX, GRANT_TIMEOUT, COOLDOWN).

- `clk` in 1: system clock, 1 Hz.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: level requests; a requester holds its bit high until served.
- `req_dir` in NUM_REQ: per-requester approach; 0 = T1 (left), 1 = T2 (right).
- `T1state` in 2: T1 light state from `traffic_signals`.
- `T2state` in 2: T2 light state from `traffic_signals`.
- `emergency_left` out 1: preempt toward T1 GREEN.
- `emergency_right` out 1: preempt toward T2 GREEN.
- `grant` out NUM_REQ: one-hot, marks the requester currently being served.
- `served` out 1: high while in HOLD, meaning the target approach is GREEN.
- `fault` out 1: one-cycle pulse on GRANT_TIMEOUT expiry.

## Operation
- Light encoding: RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10. 2'b11 is treated as not GREEN.
- **IDLE**
  - All outputs low.
  - If any `req` bit is set, pick the first set bit scanning upward from `ptr+1`, wrapping at NUM_REQ.
  - Latch that index and its `req_dir`, set `ptr` to the index, clear the counter, and go to GRANT.
- **GRANT**
  - Drive `grant[idx]`.
  - Drive `emergency_left` if dir = 0, else `emergency_right`.
  - When the target state equals GREEN, go to HOLD with the counter cleared.
  - If `req[idx]` drops, go to COOLDOWN with no fault.
  - If the counter reaches GRANT_TIMEOUT−1 without GREEN, pulse `fault` and go to COOLDOWN.
- **HOLD**
  - Same emergency line and `grant` as GRANT, plus `served` = 1.
  - Release to COOLDOWN when the counter ≥ HOLD_MIN−1 and `req[idx]` = 0, or when the counter reaches HOLD_MAX−1, whichever comes first.
- **COOLDOWN**
  - `grant`, `served` and both emergency lines are low.
  - After COOLDOWN ticks, return to IDLE.
  - Requests arriving here are not latched; they are re-sampled in IDLE.
- Counter: a single CNT_W-bit up-counter, cleared on every state entry, saturating at all-ones.
- Invariants:
  - `emergency_left` & `emergency_right` is never 1.
  - `grant` is zero or one-hot.
  - A requester that dropped early in HOLD stays held until HOLD_MIN.
- Fairness: round-robin means a continuously asserted requester is served at least once every NUM_REQ grants.

## Timing
- All outputs are registered.
- Reset values: `emergency_left` = `emergency_right` = 0, `grant` = 0, `served` = 0, `fault` = 0, state IDLE, `ptr` = NUM_REQ−1 so requester 0 wins first.
- Request latency: a `req` seen high in IDLE at edge n produces `grant` and the emergency line from edge n+1.
- GREEN detection: the GREEN state sampled at edge m sets `served` from edge m+1.
- Release: the HOLD exit condition at edge k drops the emergency line and `grant` from edge k+1. The next grant can appear no earlier than edge k+1+COOLDOWN+1.
- Simultaneous requests in IDLE: only the round-robin winner is granted; the others wait.
- Target already GREEN at grant: HOLD is entered one cycle after GRANT, with no shortcut.
- Reset asserted mid-operation: all outputs are at their reset values from the next edge, and `ptr` is reset.

## Structure
- Shared package `traffic_pkg`:
  - light-state constants RED, GREEN, YELLOW;
  - arbiter state enum IDLE, GRANT, HOLD, COOLDOWN.
  - `traffic_signals` is to migrate to the same package.
- One sub-module `rr_pick`: combinational round-robin picker.
  - Inputs `req[NUM_REQ]` and `ptr`.
  - Outputs `valid` and `idx`.
- The arbiter FSM, counter and output registers live in the top module.

## Test plan
- **Reset, single request:** reset for 3 ticks; `req` = 4'b0100, `req_dir[2]` = 1 → `grant` = 4'b0100 and `emergency_right` = 1 one tick later.
  - Model T2 GREEN after 4 ticks → `served` = 1 the next tick.
  - Drop `req` after 3 ticks of HOLD → release after 10 HOLD ticks, followed by 5 cooldown ticks.
- **Round-robin:** `req` = 4'b1011 held, all dir = 0, GREEN immediate, each requester drops after HOLD_MIN → grant order 0, 1, 3, 0.
- **HOLD_MAX:** a requester never drops `req` → `emergency_left` falls after exactly 30 HOLD ticks, then the next grant goes to another pending requester.
- **Timeout:** target light held RED → `fault` pulses once after 15 GRANT ticks, emergency lines go low, and the requester is re-granted only after cooldown.
- **Abort and reset:**
  - Requester drops during GRANT → COOLDOWN with `fault` = 0.
  - Reset asserted in HOLD → all outputs 0 on the next edge.
  - Checked every cycle: `emergency_left` & `emergency_right` == 0, and `grant` is zero or one-hot.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller blocks: light encodings
// and the emergency preemption arbiter state machine.
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t RED    = 2'b00;
  localparam light_t GREEN  = 2'b01;
  localparam light_t YELLOW = 2'b10;

  // Prefixed so the COOLDOWN state cannot collide with the COOLDOWN tick parameter.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT    = 2'b01,
    ST_HOLD     = 2'b10,
    ST_COOLDOWN = 2'b11
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr+1, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from farthest to nearest so the nearest candidate after ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[IDX_W'(j)]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/emergency_preempt_arbiter.sv
// Grants emergency preemption to one roadside detector at a time, waits for
// the target approach to go GREEN, holds it for a bounded time, then cools down.
module emergency_preempt_arbiter
  import traffic_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int HOLD_MIN      = 10,
  parameter int HOLD_MAX      = 30,
  parameter int GRANT_TIMEOUT = 15,
  parameter int COOLDOWN      = 5,
  parameter int CNT_W         = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_dir,
  input  logic [1:0]         T1state,
  input  logic [1:0]         T2state,
  output logic               emergency_left,
  output logic               emergency_right,
  output logic [NUM_REQ-1:0] grant,
  output logic               served,
  output logic               fault
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_MIN_LAST = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] COOL_LAST     = CNT_W'(COOLDOWN - 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               dir_q, dir_d;
  logic               emergency_left_q, emergency_left_d;
  logic               emergency_right_q, emergency_right_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               served_q, served_d;
  logic               fault_q, fault_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               target_green;
  logic               req_cur;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      idx_q             <= '0;
      ptr_q             <= IDX_W'(NUM_REQ - 1);
      dir_q             <= 1'b0;
      emergency_left_q  <= 1'b0;
      emergency_right_q <= 1'b0;
      grant_q           <= '0;
      served_q          <= 1'b0;
      fault_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      idx_q             <= idx_d;
      ptr_q             <= ptr_d;
      dir_q             <= dir_d;
      emergency_left_q  <= emergency_left_d;
      emergency_right_q <= emergency_right_d;
      grant_q           <= grant_d;
      served_q          <= served_d;
      fault_q           <= fault_d;
    end
  end

  always_comb begin
    target_green = dir_q ? (T2state == GREEN) : (T1state == GREEN);
    req_cur      = req[idx_q];
    cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    ptr_d        = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          dir_d   = req_dir[pick_idx];
          ptr_d   = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (target_green)               state_d = ST_HOLD;
        else if (!req_cur)              state_d = ST_COOLDOWN;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_COOLDOWN;
      end
      ST_HOLD: begin
        if ((cnt_q >= HOLD_MIN_LAST && !req_cur) || cnt_q == HOLD_MAX_LAST)
          state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cnt_q == COOL_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state entry restarts the tick count.
    cnt_d = (state_d != state_q) ? '0 : cnt_inc;
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    grant_d           = '0;
    emergency_left_d  = 1'b0;
    emergency_right_d = 1'b0;
    served_d          = (state_d == ST_HOLD);
    fault_d           = (state_q == ST_GRANT) && (state_d == ST_COOLDOWN) && req_cur;
    if (state_d == ST_GRANT || state_d == ST_HOLD) begin
      grant_d[idx_d]    = 1'b1;
      emergency_left_d  = ~dir_d;
      emergency_right_d = dir_d;
    end
  end

  assign emergency_left  = emergency_left_q;
  assign emergency_right = emergency_right_q;
  assign grant           = grant_q;
  assign served          = served_q;
  assign fault           = fault_q;

endmodule
